// File: rtl/speed_tick_gen.sv
// Multi-channel speed-controlled tick generator.
// Each channel produces a 50 % duty divided clock with half-period BASE_DIV >> speed
// and a one-cycle tick on every divided-clock rising edge. Speed and mode are only
// re-sampled at full-period boundaries, so div_clk_o never glitches. A global sync
// realigns all channels.
module speed_tick_gen #(
  parameter int unsigned CH       = 4,
  parameter int unsigned SPEED_W  = 4,
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned BASE_DIV = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*SPEED_W-1:0] speed_i,
  input  logic [CH-1:0]         mode_i,
  input  logic [CH-1:0]         step_i,
  input  logic                  sync_i,
  output logic [CH-1:0]         div_clk_o,
  output logic [CH-1:0]         tick_o,
  output logic [CH-1:0]         running_o
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SPEED_W-1:0] act_spd_q, act_spd_d;
    logic               div_q, div_d;
    logic               tick_q, tick_d;
    logic               run_q, run_d;
    logic [SPEED_W-1:0] spd_in;
    logic [CNT_W-1:0]   half;
    logic               at_end;
    logic               restart;

    assign spd_in = speed_i[i*SPEED_W +: SPEED_W];

    // Half-period for the active speed; a shift down to zero clamps to one cycle.
    always_comb begin
      half = CNT_W'(BASE_DIV >> act_spd_q);
      if (half == '0) begin
        half = CNT_W'(1);
      end
    end

    assign at_end = (cnt_q == half - CNT_W'(1));

    // Next-state: sync first, then idle start / half-period / full-period boundary.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_spd_d = act_spd_q;
      div_d     = div_q;
      tick_d    = 1'b0;
      run_d     = run_q;
      restart   = 1'b0;

      if (sync_i) begin
        if (!mode_i[i] && (spd_in != '0)) begin
          restart = 1'b1;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
          div_d   = 1'b0;
          run_d   = 1'b0;
        end
      end else begin
        case (state_q)
          StIdle: begin
            // Free-run starts on any nonzero speed; single-step needs a step pulse too.
            if ((spd_in != '0) && (!mode_i[i] || step_i[i])) begin
              restart = 1'b1;
            end
          end
          StHigh: begin
            if (at_end) begin
              cnt_d   = '0;
              div_d   = 1'b0;
              state_d = StLow;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          StLow: begin
            if (at_end) begin
              // Full-period boundary: the only point where speed and mode are honoured.
              if (!mode_i[i] && (spd_in != '0)) begin
                restart = 1'b1;
              end else begin
                state_d = StIdle;
                cnt_d   = '0;
                run_d   = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = StIdle;
            cnt_d   = '0;
            div_d   = 1'b0;
            run_d   = 1'b0;
          end
        endcase
      end

      if (restart) begin
        state_d   = StHigh;
        cnt_d     = '0;
        act_spd_d = spd_in;
        div_d     = 1'b1;
        tick_d    = 1'b1;
        run_d     = 1'b1;
      end
    end

    // Channel state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        act_spd_q <= '0;
        div_q     <= 1'b0;
        tick_q    <= 1'b0;
        run_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        act_spd_q <= act_spd_d;
        div_q     <= div_d;
        tick_q    <= tick_d;
        run_q     <= run_d;
      end
    end

    assign div_clk_o[i] = div_q;
    assign tick_o[i]    = tick_q;
    assign running_o[i] = run_q;
  end

endmodule

// File: tb/tb_speed_tick_gen.sv
// Bench for speed_tick_gen: directed vector table, async reset sequences and a
// randomized run checked against a period-position reference model.
module tb_speed_tick_gen;

  localparam int unsigned CH       = 4;
  localparam int unsigned SPEED_W  = 4;
  localparam int unsigned CNT_W    = 20;
  localparam int unsigned BASE_DIV = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [CH*SPEED_W-1:0] speed_i = '0;
  logic [CH-1:0]         mode_i = '0;
  logic [CH-1:0]         step_i = '0;
  logic                  sync_i = 1'b0;
  logic [CH-1:0]         div_clk_o, tick_o, running_o;

  int vectors = 0;
  int miscompares = 0;

  speed_tick_gen #(
    .CH      (CH),
    .SPEED_W (SPEED_W),
    .CNT_W   (CNT_W),
    .BASE_DIV(BASE_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .speed_i  (speed_i),
    .mode_i   (mode_i),
    .step_i   (step_i),
    .sync_i   (sync_i),
    .div_clk_o(div_clk_o),
    .tick_o   (tick_o),
    .running_o(running_o)
  );

  always #5 clk = ~clk;

  // Reference model: each running channel is a position within a 2H-cycle period.
  bit m_run [CH];
  int m_pos [CH];
  int m_h   [CH];

  function automatic int half_of(input int spd);
    int h;
    h = int'(BASE_DIV >> spd) & ((1 << CNT_W) - 1);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 1'b0;
      m_pos[c] = 0;
      m_h[c]   = 1;
    end
  endfunction

  function automatic void model_clock();
    for (int c = 0; c < CH; c++) begin
      int spd;
      bit go, stop;
      spd  = int'(speed_i[c*SPEED_W +: SPEED_W]);
      go   = 1'b0;
      stop = 1'b0;
      if (sync_i) begin
        if (!mode_i[c] && spd != 0) go = 1'b1;
        else stop = 1'b1;
      end else if (!m_run[c]) begin
        go = (spd != 0) && (!mode_i[c] || step_i[c]);
      end else if (m_pos[c] == 2 * m_h[c] - 1) begin
        if (!mode_i[c] && spd != 0) go = 1'b1;
        else stop = 1'b1;
      end else begin
        m_pos[c]++;
      end
      if (go) begin
        m_run[c] = 1'b1;
        m_pos[c] = 0;
        m_h[c]   = half_of(spd);
      end
      if (stop) begin
        m_run[c] = 1'b0;
        m_pos[c] = 0;
      end
    end
  endfunction

  function automatic void model_outputs(output logic [CH-1:0] d, output logic [CH-1:0] t,
                                        output logic [CH-1:0] r);
    for (int c = 0; c < CH; c++) begin
      d[c] = m_run[c] && (m_pos[c] < m_h[c]);
      t[c] = m_run[c] && (m_pos[c] == 0);
      r[c] = m_run[c];
    end
  endfunction

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One rising edge (model advances alongside), then return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  typedef struct {
    logic [CH*SPEED_W-1:0] spd;
    logic [CH-1:0]         md;
    logic [CH-1:0]         st;
    logic                  sy;
    int                    reps;
    logic [CH-1:0]         d;
    logic [CH-1:0]         t;
    logic [CH-1:0]         r;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [15:0] spd, input logic [3:0] md, input logic [3:0] st,
                              input logic sy, input int reps, input logic [3:0] d,
                              input logic [3:0] t, input logic [3:0] r);
    vec_t v;
    v.spd  = spd;
    v.md   = md;
    v.st   = st;
    v.sy   = sy;
    v.reps = reps;
    v.d    = d;
    v.t    = t;
    v.r    = r;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [CH-1:0] ed, et, er;

    // spd, mode, step, sync, reps, div_clk, tick, running
    add(16'h0000, 4'h0, 4'h0, 1'b0, 2, 4'h0, 4'h0, 4'h0);  // idle after reset
    add(16'h0001, 4'h0, 4'h0, 1'b0, 1, 4'h1, 4'h1, 4'h1);  // ch0 H=8 starts
    add(16'h0001, 4'h0, 4'h0, 1'b0, 3, 4'h1, 4'h0, 4'h1);
    add(16'h0003, 4'h0, 4'h0, 1'b0, 4, 4'h1, 4'h0, 4'h1);  // speed change mid-HIGH
    add(16'h0003, 4'h0, 4'h0, 1'b0, 8, 4'h0, 4'h0, 4'h1);  // old period completes
    add(16'h0003, 4'h0, 4'h0, 1'b0, 1, 4'h1, 4'h1, 4'h1);  // H=2 from here
    add(16'h0003, 4'h0, 4'h0, 1'b0, 1, 4'h1, 4'h0, 4'h1);
    add(16'h0003, 4'h0, 4'h0, 1'b0, 2, 4'h0, 4'h0, 4'h1);
    add(16'h0003, 4'h0, 4'h0, 1'b0, 1, 4'h1, 4'h1, 4'h1);
    add(16'h0000, 4'h0, 4'h0, 1'b0, 1, 4'h1, 4'h0, 4'h1);  // stop mid-HIGH
    add(16'h0000, 4'h0, 4'h0, 1'b0, 2, 4'h0, 4'h0, 4'h1);
    add(16'h0000, 4'h0, 4'h0, 1'b0, 3, 4'h0, 4'h0, 4'h0);
    add(16'h0007, 4'h0, 4'h0, 1'b0, 1, 4'h1, 4'h1, 4'h1);  // H clamps to 1
    add(16'h0007, 4'h0, 4'h0, 1'b0, 1, 4'h0, 4'h0, 4'h1);
    add(16'h0007, 4'h0, 4'h0, 1'b0, 1, 4'h1, 4'h1, 4'h1);
    add(16'h0007, 4'h0, 4'h0, 1'b0, 1, 4'h0, 4'h0, 4'h1);
    add(16'h0000, 4'h0, 4'h0, 1'b0, 2, 4'h0, 4'h0, 4'h0);
    add(16'h0020, 4'h2, 4'h0, 1'b0, 2, 4'h0, 4'h0, 4'h0);  // ch1 single-step waits
    add(16'h0020, 4'h2, 4'h2, 1'b0, 1, 4'h2, 4'h2, 4'h2);  // step: one period, H=4
    add(16'h0020, 4'h2, 4'h0, 1'b0, 2, 4'h2, 4'h0, 4'h2);
    add(16'h0020, 4'h2, 4'h2, 1'b0, 1, 4'h2, 4'h0, 4'h2);  // step while running ignored
    add(16'h0020, 4'h2, 4'h0, 1'b0, 4, 4'h0, 4'h0, 4'h2);
    add(16'h0020, 4'h2, 4'h0, 1'b0, 3, 4'h0, 4'h0, 4'h0);
    add(16'h0000, 4'h2, 4'h2, 1'b0, 1, 4'h0, 4'h0, 4'h0);  // step at speed 0 ignored
    add(16'h0001, 4'h0, 4'h0, 1'b0, 1, 4'h1, 4'h1, 4'h1);  // ch0 H=8
    add(16'h0001, 4'h0, 4'h0, 1'b0, 2, 4'h1, 4'h0, 4'h1);
    add(16'h0201, 4'h0, 4'h0, 1'b0, 1, 4'h5, 4'h4, 4'h5);  // ch2 H=4, out of phase
    add(16'h0201, 4'h0, 4'h0, 1'b0, 3, 4'h5, 4'h0, 4'h5);
    add(16'h0201, 4'h0, 4'h0, 1'b0, 1, 4'h1, 4'h0, 4'h5);
    add(16'h0201, 4'h0, 4'h0, 1'b1, 1, 4'h5, 4'h5, 4'h5);  // sync realigns both
    add(16'h0201, 4'h0, 4'h0, 1'b0, 1, 4'h5, 4'h0, 4'h5);

    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("reset div_clk", div_clk_o, '0);
    check("reset tick", tick_o, '0);
    check("reset running", running_o, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      speed_i = tbl[i].spd;
      mode_i  = tbl[i].md;
      step_i  = tbl[i].st;
      sync_i  = tbl[i].sy;
      for (int r = 0; r < tbl[i].reps; r++) begin
        cycle();
        check($sformatf("row%0d.%0d div_clk", i, r), div_clk_o, tbl[i].d);
        check($sformatf("row%0d.%0d tick", i, r), tick_o, tbl[i].t);
        check($sformatf("row%0d.%0d running", i, r), running_o, tbl[i].r);
      end
    end

    // Asynchronous reset while ch0/ch2 are in HIGH: outputs clear without a clock edge.
    sync_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midhigh reset div_clk", div_clk_o, '0);
    check("midhigh reset tick", tick_o, '0);
    check("midhigh reset running", running_o, '0);
    @(negedge clk);
    speed_i = '0;
    mode_i  = '0;
    step_i  = '0;
    model_reset();
    rst_n = 1'b1;

    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 19) == 0) begin
          speed_i[c*SPEED_W +: SPEED_W] = SPEED_W'($urandom_range(0, 7));
        end
        if ($urandom_range(0, 59) == 0) begin
          mode_i[c] = ~mode_i[c];
        end
        step_i[c] = ($urandom_range(0, 5) == 0);
      end
      sync_i = ($urandom_range(0, 79) == 0);
      if (n == 2000) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        model_outputs(ed, et, er);
        check("rand reset div_clk", div_clk_o, ed);
        check("rand reset tick", tick_o, et);
        check("rand reset running", running_o, er);
        rst_n = 1'b1;
      end
      cycle();
      model_outputs(ed, et, er);
      check($sformatf("rand%0d div_clk", n), div_clk_o, ed);
      check($sformatf("rand%0d tick", n), tick_o, et);
      check($sformatf("rand%0d running", n), running_o, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/speed_tick_gen.md
# speed_tick_gen

Multi-channel, parametrised speed-controlled clock/tick generator. Each channel derives a 50 %-duty divided clock and a one-cycle tick from the system clock, with half-period BASE_DIV >> speed. Speed changes and stops take effect only at full-period boundaries, so divided clocks never glitch. Channels run free or deliver one period per step pulse, and a global sync realigns all channels. It sits between the user speed controls and the animation/stepper logic that consume the ticks.

## Interface
- CH, 4: number of independent channels.
- SPEED_W, 4: width of each channel's speed code.
- CNT_W, 20: half-period counter width; BASE_DIV must be < 2^CNT_W.
- BASE_DIV, 1000000: half-period in clk cycles at speed code 0 shift (H = BASE_DIV >> speed).

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- speed  in  CH*SPEED_W  per-channel speed code; channel i = bits [i*SPEED_W +: SPEED_W]; code 0 = stop.
- mode  in  CH  per-channel mode; 0 = free-run, 1 = single-step.
- step  in  CH  per-channel one-cycle step request (used only in single-step mode).
- sync  in  1  synchronous restart of all channels.
- div_clk  out  CH  divided clock, 50 % duty, period 2H.
- tick  out  CH  one-cycle pulse coincident with each div_clk rising edge.
- running  out  CH  1 while channel is generating a period.

## Operation
- Per channel: active speed register act_spd, active mode act_mode, counter cnt[CNT_W-1:0], div_clk, tick, running.
- H = BASE_DIV >> act_spd, truncated to CNT_W; H == 0 clamps to 1, giving period 2.
- States per channel: IDLE (running=0, div_clk=0, cnt=0), HIGH (div_clk=1), LOW (div_clk=0, running=1).
- IDLE, free-run: if speed != 0, load act_spd and act_mode, set cnt=0, div_clk=1, tick=1, and go to HIGH.
- IDLE, single-step: on step=1 with speed != 0, load the same values and go to HIGH. step with speed 0 is ignored.
- HIGH: cnt increments. At cnt == H-1, set cnt=0, div_clk=0, and go to LOW. act_spd is not re-sampled.
- LOW: cnt increments. At cnt == H-1 (full-period boundary), sample speed and mode:
  - free-run with speed != 0: load the new act_spd, set div_clk=1, tick=1, and go to HIGH.
  - speed == 0, or single-step mode: go to IDLE.
- step while running is ignored.
- mode changes while running are honoured only at the boundary.
- sync=1: every channel clears cnt, div_clk and tick. Free-run channels with speed != 0 restart as from IDLE on that same edge, so div_clk=1 and tick=1 the next cycle. All other channels go to IDLE.
- sync has priority over step and over boundary processing.
- Channels are fully independent apart from sync.

## Timing
- Reset (asynchronous): div_clk=0, tick=0, running=0, cnt=0, act_spd=0, act_mode=0 for all channels.
- Start latency: speed applied (or step asserted) at edge k gives div_clk=1, tick=1 and running=1 visible after edge k.
- div_clk is high exactly H cycles and low exactly H cycles.
- tick is high exactly 1 cycle per period, in the first cycle of HIGH.
- Speed change mid-period: the old H completes both halves, and the new H starts with the next rising edge. There is no partial period.
- Stop (speed→0): the current period completes, div_clk ends low, and running falls on the boundary edge.
- Reset mid-period: outputs clear immediately; there is no completion of the period.
- Simultaneous sync and boundary on the same edge: sync wins and cnt restarts at 0.

## Test plan
- BASE_DIV=16, ch0 free-run, speed 0→1 at edge 10. Required: div_clk high at cycles 11–18 and low at 19–26; tick at 11, 27, 43; running=1 from cycle 11.
- Change speed 1→3 at cycle 14, mid-HIGH. Required: the period 11–26 is unchanged; from cycle 27, div_clk is high 2 and low 2, with ticks at 27, 31, 35.
- speed 1→0 at cycle 20. Required: div_clk stays low through cycle 26; running=0 from cycle 27; no further ticks.
- speed=7 (H=0 clamps to 1). Required: div_clk toggles every cycle and tick occurs every 2 cycles.
- ch1 single-step, speed=2 (H=4), step at cycle 5 and again at cycle 8. Required: exactly one period (high 6–9, low 10–13) and one tick at cycle 6; the second step is ignored; running=0 from cycle 14.
- Two channels at speed 1 and 2 running out of phase, sync at cycle 30. Required: both show div_clk=1 and tick=1 at cycle 31. Separately, assert rst_n=0 mid-HIGH: all outputs are 0 immediately.
